// File: rtl/fifo_rd_arbiter_pkg.sv
// Shared definitions for the FIFO read-side arbiter.
//   - FIFO fill-status encoding reported by the FIFO controller
//   - Arbiter FSM state type
package fifo_rd_arbiter_pkg;

  typedef logic [2:0] fifo_status_t;

  localparam fifo_status_t ST_EMPTY = 3'd0;
  localparam fifo_status_t ST_Q1    = 3'd1;
  localparam fifo_status_t ST_Q2    = 3'd2;
  localparam fifo_status_t ST_Q3    = 3'd3;
  localparam fifo_status_t ST_Q4    = 3'd4;
  localparam fifo_status_t ST_FULL  = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// Requester-side bus of the FIFO read arbiter.
//   req_valid  per-requester read request (held until its response completes)
//   req_peek   per-requester mode: 1 = peek, 0 = pop
//   resp_valid one-hot response valid
//   resp_ready per-requester response accept
//   resp_data  shared response data
//   grant_id   index of the current or last granted requester
// master: requester side, slave: arbiter side.
interface fifo_rd_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = 2
);

  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_peek;
  logic [NREQ-1:0]  resp_valid;
  logic [NREQ-1:0]  resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic [IDW-1:0]   grant_id;

  modport master (
    output req_valid,
    output req_peek,
    output resp_ready,
    input  resp_valid,
    input  resp_data,
    input  grant_id
  );

  modport slave (
    input  req_valid,
    input  req_peek,
    input  resp_ready,
    output resp_valid,
    output resp_data,
    output grant_id
  );

endinterface

// File: rtl/fifo_rd_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   eligible_i  candidate vector
//   ptr_i       highest-priority index (must be < NREQ)
//   found_o     at least one candidate present
//   winner_o    first eligible index at or after ptr_i, wrapping NREQ-1 -> 0
module rr_picker #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] eligible_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic            found_o,
  output logic [IDW-1:0]  winner_o
);

  always_comb begin
    int unsigned   sum;
    logic [IDW-1:0] idx;
    found_o  = 1'b0;
    winner_o = '0;
    sum      = 0;
    idx      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      // ptr_i < NREQ, so one conditional subtract is enough to wrap.
      sum = 32'(ptr_i) + k;
      if (sum >= NREQ) begin
        sum = sum - NREQ;
      end
      idx = IDW'(sum);
      if (!found_o && eligible_i[idx]) begin
        found_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter owning the FIFO read port.
// One transaction in flight: IDLE -> ISSUE (rd_en) -> WAIT (capture data)
// -> RESP (valid/ready handshake) -> IDLE.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          requester bus (fifo_rd_arbiter_if.slave)
//   busy         high whenever not IDLE
//   rd_en        FIFO read enable, one cycle in ISSUE
//   rd_only      peek qualifier accompanying rd_en
//   fifo_status  FIFO fill level: 0 empty, 1..4 quarters, 5 full
//   fifo_rdata   FIFO read data, valid the cycle after rd_en
module fifo_rd_arbiter
  import fifo_rd_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_rd_arbiter_if.slave     bus,
  output logic                 busy,
  output logic                 rd_en,
  output logic                 rd_only,
  input  logic [2:0]           fifo_status,
  input  logic [WIDTH-1:0]     fifo_rdata
);

  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  state_e           state_q, state_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   ptr_q,   ptr_d;
  logic             peek_q,  peek_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  pops;
  logic             found;
  logic [IDW-1:0]   winner;
  logic             handshake;
  logic [NREQ-1:0]  resp_valid;

  // Eligibility only matters in IDLE. When full, pops are preferred so the
  // FIFO drains; peeks still win if nothing else is pending.
  always_comb begin
    eligible = '0;
    pops     = bus.req_valid & ~bus.req_peek;
    if (state_q == IDLE) begin
      if (fifo_status == ST_EMPTY) begin
        eligible = '0;
      end else if (fifo_status == ST_FULL) begin
        eligible = (|pops) ? pops : bus.req_valid;
      end else begin
        eligible = bus.req_valid;
      end
    end
  end

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_picker (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .found_o    (found),
    .winner_o   (winner)
  );

  assign handshake = (state_q == RESP) && bus.resp_ready[grant_q];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found)     state_d = ISSUE;
      ISSUE:                  state_d = WAIT;
      WAIT:                   state_d = RESP;
      RESP:    if (handshake) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy       = (state_q != IDLE);
    rd_en      = (state_q == ISSUE);
    rd_only    = (state_q == ISSUE) && peek_q;
    resp_valid = '0;
    if (state_q == RESP) begin
      resp_valid[grant_q] = 1'b1;
    end
  end

  // Transaction datapath: grant/peek latched at grant, data captured in WAIT,
  // pointer advances past the winner only once its response is accepted.
  always_comb begin
    grant_d = grant_q;
    peek_d  = peek_q;
    ptr_d   = ptr_q;
    rdata_d = rdata_q;
    if ((state_q == IDLE) && found) begin
      grant_d = winner;
      peek_d  = bus.req_peek[winner];
    end
    if (state_q == WAIT) begin
      rdata_d = fifo_rdata;
    end
    if (handshake) begin
      ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + IDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      peek_q  <= 1'b0;
      ptr_q   <= '0;
      rdata_q <= '0;
    end else begin
      grant_q <= grant_d;
      peek_q  <= peek_d;
      ptr_q   <= ptr_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = rdata_q;
  assign bus.grant_id   = grant_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: directed scenarios followed by randomized
// traffic, every cycle compared against a transaction-level reference model.
module tb_fifo_rd_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             busy, rd_en, rd_only;
  logic [2:0]       fifo_status;
  logic [WIDTH-1:0] fifo_rdata;

  always #5 clk = ~clk;

  fifo_rd_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus_if ();

  fifo_rd_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .busy        (busy),
    .rd_en       (rd_en),
    .rd_only     (rd_only),
    .fifo_status (fifo_status),
    .fifo_rdata  (fifo_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // FIFO environment: contents queue, registered read data.
  logic [WIDTH-1:0] q[$];
  bit               rd_pend, rd_pend_peek;
  int               push_pct = 0;

  function automatic logic [2:0] status_of(input int n);
    if (n == 0) return 3'd0;
    if (n >= DEPTH) return 3'd5;
    return 3'(1 + (n - 1) / 4);
  endfunction

  task automatic upd_status();
    fifo_status = status_of(q.size());
  endtask

  task automatic fill_to(input int n);
    while (q.size() < n) q.push_back($urandom);
    upd_status();
  endtask

  // Reference model: one transaction at a time, age counts cycles since grant
  // (1 = read issued, 2 = data returning, 3 = response offered).
  bit               m_act;
  int               m_age, m_gnt, m_ptr;
  bit               m_peek;
  logic [WIDTH-1:0] m_data;
  logic [NREQ-1:0]  hs_mask;

  task automatic model_reset();
    m_act = 0; m_age = 0; m_gnt = 0; m_ptr = 0; m_peek = 0; m_data = '0;
    hs_mask = '0; rd_pend = 0; rd_pend_peek = 0;
  endtask

  task automatic model_step();
    logic [NREQ-1:0] rv, rp, elig;
    rv = bus_if.req_valid;
    rp = bus_if.req_peek;
    hs_mask = '0;
    if (!m_act) begin
      if (fifo_status == 3'd0) elig = '0;
      else if (fifo_status == 3'd5) begin
        elig = rv & ~rp;
        if (elig == '0) elig = rv;
      end else elig = rv;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (elig[i]) begin
          m_act = 1; m_age = 1; m_gnt = i; m_peek = rp[i];
          break;
        end
      end
    end else if (m_age == 3) begin
      if (bus_if.resp_ready[m_gnt]) begin
        m_act = 0;
        hs_mask[m_gnt] = 1'b1;
        m_ptr = (m_gnt + 1) % NREQ;
      end
    end else begin
      if (m_age == 2) m_data = fifo_rdata;
      m_age++;
    end
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] ev;
    ev = '0;
    if (m_act && m_age == 3) ev[m_gnt] = 1'b1;
    chk("busy",       64'(busy),              64'(m_act));
    chk("rd_en",      64'(rd_en),             64'(m_act && m_age == 1));
    chk("rd_only",    64'(rd_only),           64'(m_act && m_age == 1 && m_peek));
    chk("resp_valid", 64'(bus_if.resp_valid), 64'(ev));
    chk("grant_id",   64'(bus_if.grant_id),   64'(m_gnt));
    chk("resp_data",  64'(bus_if.resp_data),  64'(m_data));
  endtask

  task automatic env_step();
    if (rd_pend && q.size() > 0) begin
      fifo_rdata = q[0];
      if (!rd_pend_peek) void'(q.pop_front());
    end else begin
      fifo_rdata = $urandom;
    end
    rd_pend      = rd_en;
    rd_pend_peek = rd_only;
    if (q.size() < DEPTH && $urandom_range(0, 99) < push_pct) q.push_back($urandom);
    upd_status();
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    model_step();
    check_outputs();
    env_step();
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_busy"},       64'(busy),              64'(0));
    chk({pfx, "_rd_en"},      64'(rd_en),             64'(0));
    chk({pfx, "_rd_only"},    64'(rd_only),           64'(0));
    chk({pfx, "_resp_valid"}, 64'(bus_if.resp_valid), 64'(0));
    chk({pfx, "_grant_id"},   64'(bus_if.grant_id),   64'(0));
    chk({pfx, "_resp_data"},  64'(bus_if.resp_data),  64'(0));
  endtask

  // Asserts reset between clock edges, checks outputs before any edge.
  task automatic apply_reset(input string pfx);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero(pfx);
    model_reset();
    bus_if.req_valid  = '0;
    bus_if.req_peek   = '0;
    bus_if.resp_ready = '0;
    @(negedge clk);
    rst_n = 1'b1;
    fifo_rdata = $urandom;
  endtask

  task automatic random_drive();
    for (int i = 0; i < NREQ; i++) begin
      if (hs_mask[i]) bus_if.req_valid[i] = 1'($urandom_range(0, 1));
      else if (bus_if.req_valid[i]) begin
        if (m_act && m_gnt == i && $urandom_range(0, 7) == 0) bus_if.req_valid[i] = 1'b0;
      end else bus_if.req_valid[i] = ($urandom_range(0, 3) == 0);
    end
    bus_if.req_peek   = 4'($urandom);
    bus_if.resp_ready = 4'($urandom);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [WIDTH-1:0] head;
    rst_n = 1'b0;
    bus_if.req_valid  = '0;
    bus_if.req_peek   = '0;
    bus_if.resp_ready = '0;
    fifo_rdata = '0;
    q.delete();
    upd_status();
    model_reset();
    #12;
    check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Single pop with known head data at quarter-2 fill.
    q.push_back(32'hA5A5_0001);
    fill_to(5);
    chk("pop_status", 64'(fifo_status), 64'(2));
    bus_if.req_valid = 4'b0001;
    cycle();
    chk("pop_rd_en", 64'(rd_en), 64'(1));
    chk("pop_rd_only", 64'(rd_only), 64'(0));
    cycle();
    chk("pop_rd_en_1cyc", 64'(rd_en), 64'(0));
    cycle();
    chk("pop_resp_valid", 64'(bus_if.resp_valid), 64'(4'b0001));
    chk("pop_resp_data", 64'(bus_if.resp_data), 64'(32'hA5A5_0001));
    bus_if.resp_ready = 4'b0001;
    cycle();
    chk("pop_resp_clear", 64'(bus_if.resp_valid), 64'(0));
    bus_if.req_valid = '0;
    bus_if.resp_ready = '0;
    cycle();

    // Peek from requester 2.
    bus_if.req_valid = 4'b0100;
    bus_if.req_peek  = 4'b0100;
    cycle();
    chk("peek_rd_en", 64'(rd_en), 64'(1));
    chk("peek_rd_only", 64'(rd_only), 64'(1));
    chk("peek_grant", 64'(bus_if.grant_id), 64'(2));
    cycle();
    cycle();
    chk("peek_resp_valid", 64'(bus_if.resp_valid), 64'(4'b0100));
    bus_if.resp_ready = 4'b0100;
    cycle();
    bus_if.req_valid = '0;
    bus_if.req_peek  = '0;
    bus_if.resp_ready = '0;

    // Round-robin among four continuous poppers.
    apply_reset("rr_rst");
    fill_to(12);
    bus_if.req_valid  = 4'b1111;
    bus_if.resp_ready = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      cycle();
      chk("rr_rd_en", 64'(rd_en), 64'(1));
      chk("rr_grant", 64'(bus_if.grant_id), 64'(t % NREQ));
      cycle();
      cycle();
      chk("rr_resp_valid", 64'(bus_if.resp_valid), 64'(1) << (t % NREQ));
      if (t == 4) bus_if.req_valid = '0;
      cycle();
      chk("rr_idle", 64'(busy), 64'(0));
    end

    // Empty FIFO blocks all grants.
    apply_reset("empty_rst");
    q.delete();
    upd_status();
    bus_if.req_valid = 4'b1111;
    for (int t = 0; t < 10; t++) begin
      cycle();
      chk("empty_rd_en", 64'(rd_en), 64'(0));
      chk("empty_busy", 64'(busy), 64'(0));
    end
    q.push_back(32'h0BAD_F00D);
    upd_status();
    cycle();
    chk("empty_release_rd_en", 64'(rd_en), 64'(1));
    chk("empty_release_grant", 64'(bus_if.grant_id), 64'(0));
    bus_if.resp_ready = 4'b1111;
    cycle();
    cycle();
    chk("empty_release_data", 64'(bus_if.resp_data), 64'(32'h0BAD_F00D));
    bus_if.req_valid = '0;
    cycle();
    bus_if.resp_ready = '0;

    // Full FIFO: pop preferred over a peek ahead of it.
    apply_reset("full_rst");
    fill_to(DEPTH);
    chk("full_status", 64'(fifo_status), 64'(5));
    bus_if.req_valid = 4'b0011;
    bus_if.req_peek  = 4'b0001;
    cycle();
    chk("full_pop_grant", 64'(bus_if.grant_id), 64'(1));
    chk("full_pop_rd_only", 64'(rd_only), 64'(0));
    cycle();
    cycle();
    bus_if.resp_ready = 4'b0010;
    cycle();
    bus_if.req_valid = '0;
    bus_if.resp_ready = '0;
    fill_to(DEPTH);
    // Full FIFO with only peeks pending: a peek still wins.
    bus_if.req_valid = 4'b1010;
    bus_if.req_peek  = 4'b1010;
    cycle();
    chk("full_peek_rd_en", 64'(rd_en), 64'(1));
    chk("full_peek_rd_only", 64'(rd_only), 64'(1));
    chk("full_peek_grant", 64'(bus_if.grant_id), 64'(3));
    cycle();
    cycle();
    bus_if.resp_ready = 4'b1000;
    cycle();
    bus_if.req_valid = '0;
    bus_if.req_peek  = '0;
    bus_if.resp_ready = '0;

    // Backpressure in RESP, then reset mid-transaction.
    fill_to(8);
    head = q[0];
    bus_if.req_valid = 4'b0001;
    cycle();
    cycle();
    cycle();
    for (int t = 0; t < 5; t++) begin
      chk("bp_resp_valid", 64'(bus_if.resp_valid), 64'(4'b0001));
      chk("bp_resp_data", 64'(bus_if.resp_data), 64'(head));
      chk("bp_no_rd_en", 64'(rd_en), 64'(0));
      cycle();
    end
    apply_reset("arst");

    // Randomized traffic; low write rate first to exercise empty, then high.
    for (int k = 0; k < 3000; k++) begin
      push_pct = (k < 1500) ? 10 : 50;
      if (k == 1500) apply_reset("rand_rst");
      random_drive();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
- Sole owner of the FIFO read side.
- Shares one FIFO read port among NREQ requesters using round-robin arbitration. Each request is either a pop or a peek (read without pop).
- Drives rd_en/rd_only into the FIFO controller, captures the memory read data, and returns it to the granted requester with a valid/ready handshake.
- Uses the FIFO's 3-bit fill status to block grants when the FIFO is empty and to favour pops when it is full.

Parameters:
- WIDTH, 32: data bit width.
- NREQ, 4: number of requesters (2..8).
- IDW, 2: grant index width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester read request; held high until that requester's response handshake completes
- req_peek  in  NREQ  per-requester mode: 1 = peek (no pop), 0 = pop; sampled at grant
- resp_valid  out  NREQ  one-hot; response data valid for that requester
- resp_ready  in  NREQ  per-requester response accept
- resp_data  out  WIDTH  shared response data bus
- grant_id  out  IDW  index of the current or last granted requester
- busy  out  1  high in any state other than IDLE
- rd_en  out  1  FIFO read enable
- rd_only  out  1  FIFO read-only (peek) qualifier
- fifo_status  in  3  0 = empty, 1..4 = quarter fill levels, 5 = full
- fifo_rdata  in  WIDTH  FIFO memory read data, valid one cycle after rd_en

Behaviour:
- Reset values (asynchronous): state=IDLE, resp_valid=0, resp_data=0, grant_id=0, busy=0, rd_en=0, rd_only=0, round-robin pointer=0.
- FSM states and transitions:
  - IDLE -> ISSUE when an eligible request exists.
  - ISSUE -> WAIT unconditionally.
  - WAIT -> RESP unconditionally.
  - RESP -> IDLE when resp_ready[grant_id] is high.
  - Only one transaction is in flight at a time.
- Eligibility, evaluated in IDLE only:
  - fifo_status==0: nothing is eligible. Requests stay pending and no rd_en is issued.
  - fifo_status==5: eligible = req_valid & ~req_peek. If that is zero, eligible = req_valid.
  - Otherwise: eligible = req_valid.
- Arbitration:
  - Round-robin search starting at the pointer and wrapping from NREQ-1 to 0.
  - The winner is registered into grant_id on the IDLE->ISSUE edge, and its req_peek bit is latched at the same edge.
- ISSUE: rd_en=1 and rd_only=latched peek, for exactly one cycle. Both are 0 in every other state.
- WAIT: resp_data is loaded from fifo_rdata at the end of the cycle.
- RESP:
  - resp_valid[grant_id]=1 and all other bits are 0.
  - resp_data is stable until the handshake completes.
  - On handshake: resp_valid goes to 0 next cycle, the pointer becomes (grant_id+1) mod NREQ, and the state returns to IDLE.
- Latency: request visible in cycle T (IDLE) -> rd_en in T+1 -> resp_valid from T+3. Minimum 4 cycles per transaction; back-to-back grants are possible from the IDLE cycle after RESP.
- Pointer wrap: with NREQ not a power of two, the pointer never exceeds NREQ-1.
- Empty safety: the arbiter is the only reader, so the non-empty status seen in IDLE still holds at ISSUE; concurrent writes can only increase the fill.
- A requester that drops req_valid mid-transaction still receives its response. The transaction is not aborted.
- Reset asserted mid-transaction: immediate return to reset values. No response is issued, and the FIFO pointer state is owned by the FIFO controller.
- req_peek changes after grant are ignored.

Decomposition:
- Shared package contents:
  - FIFO status encoding constants: ST_EMPTY=0, ST_Q1=1, ST_Q2=2, ST_Q3=3, ST_Q4=4, ST_FULL=5.
  - FSM state encoding: IDLE, ISSUE, WAIT, RESP.
- One sub-module, rr_picker:
  - Combinational round-robin picker.
  - Inputs: eligible vector and pointer. Outputs: found flag and winner index.
  - Reusable by other arbiters in the codebase.

Test Plan:
- Single pop: fifo_status=2, req_valid=0001, req_peek=0, fifo_rdata=0xA5A5_0001 in the cycle after rd_en -> rd_en=1, rd_only=0 for one cycle; resp_valid=0001 with resp_data=0xA5A5_0001 three cycles after the request; clears the cycle after resp_ready[0].
- Peek: req_peek[2]=1, req_valid=0100 -> rd_en=1 and rd_only=1 for one cycle; resp_valid=0100.
- Round-robin: all four requesters pop continuously, resp_ready tied high -> grant order 0,1,2,3,0; each transaction takes 4 cycles.
- Empty block: fifo_status=0 with req_valid=1111 for 10 cycles -> rd_en stays 0 and busy stays 0; set fifo_status=1 -> grant to requester 0 on the next cycle.
- Full preference: fifo_status=5, pointer=0, req_valid=0011, req_peek=0001 -> requester 1 (pop) granted first. Separately, with only peeks pending at full, a peek is granted.
- Backpressure and reset: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_data stable, no new rd_en. Then assert rst_n=0 -> all outputs return to 0 asynchronously.
